// File: rtl/imm_packer.sv
// Immediate packer: scatters an expander-convention immediate into the I/S/B/J fields of a base word.
// Define IMM_PACKER_ROUNDTRIP_EN to build the round-trip expander check that drives chk_fail.
module imm_packer #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_fmt,
    input  logic [31:0]      in_base,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    input  logic             clr,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic             chk_fail
);

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b10;

    // Overwrites only the format's immediate field; every other bit comes from base.
    function automatic logic [31:0] pack_imm(input logic [1:0] fmt, input logic [31:0] base,
                                             input logic [31:0] imm);
        logic [31:0] w;
        w = base;
        case (fmt)
            FMT_I: w[31:20] = imm[11:0];
            FMT_S: begin
                w[31:25] = imm[11:5];
                w[11:7]  = imm[4:0];
            end
            FMT_B: begin
                w[31]    = imm[11];
                w[30:25] = imm[9:4];
                w[11:8]  = imm[3:0];
                w[7]     = imm[10];
            end
            default: begin
                w[31]    = imm[19];
                w[30:21] = imm[9:0];
                w[20]    = imm[10];
                w[19:12] = imm[18:11];
            end
        endcase
        return w;
    endfunction

    // The immediate fits when all bits above the field's sign bit replicate it.
    function automatic logic range_err(input logic [1:0] fmt, input logic [31:0] imm);
        logic bad;
        if (fmt == 2'b11)
            bad = (imm[31:20] != {12{imm[19]}});
        else
            bad = (imm[31:12] != {20{imm[11]}});
        return bad;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
        logic [ERR_W-1:0] nxt;
        if (cnt == {ERR_W{1'b1}})
            nxt = cnt;
        else
            nxt = cnt + ERR_W'(1);
        return nxt;
    endfunction

    logic [31:0] inst_p0;
    logic        err_p0;
    logic        acc_p0;
    logic        vld_p1;
    logic [31:0] inst_p1;
    logic        err_p1;

    assign in_ready = !vld_p1 || out_ready;
    assign acc_p0   = in_valid && in_ready;
    assign inst_p0  = pack_imm(in_fmt, in_base, in_imm);
    assign err_p0   = range_err(in_fmt, in_imm);

    // ---- p0 -> p1: output register; a new accept overrides a same-cycle drain ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            inst_p1 <= '0;
            err_p1  <= 1'b0;
        end else if (acc_p0) begin
            vld_p1  <= 1'b1;
            inst_p1 <= inst_p0;
            err_p1  <= err_p0;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_inst  = inst_p1;
    assign out_err   = err_p1;

    // Clear beats a same-cycle accept, so that accept never reaches the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_cnt <= '0;
            err_cnt <= '0;
        end else if (clr) begin
            enc_cnt <= '0;
            err_cnt <= '0;
        end else if (acc_p0) begin
            enc_cnt <= enc_cnt + CNT_W'(1);
            if (err_p0)
                err_cnt <= sat_inc(err_cnt);
        end
    end

`ifdef IMM_PACKER_ROUNDTRIP_EN
    // Inverse mapping of pack_imm, sign-extending from the field's top bit.
    function automatic logic [31:0] expand_imm(input logic [1:0] fmt, input logic [31:0] inst);
        logic signed [11:0] s12;
        logic signed [19:0] s20;
        logic signed [31:0] r;
        s12 = '0;
        s20 = '0;
        case (fmt)
            FMT_I: begin
                s12 = inst[31:20];
                r   = s12;
            end
            FMT_S: begin
                s12 = {inst[31:25], inst[11:7]};
                r   = s12;
            end
            FMT_B: begin
                s12 = {inst[31], inst[7], inst[30:25], inst[11:8]};
                r   = s12;
            end
            default: begin
                s20 = {inst[31], inst[19:12], inst[20], inst[30:21]};
                r   = s20;
            end
        endcase
        return r;
    endfunction

    logic [31:0] imm_p1;
    logic [1:0]  fmt_p1;
    logic        chk_pend_p1;
    logic        chk_fail_p2;

    // ---- p1 -> p2: compare the re-expanded output word against the accepted immediate ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm_p1      <= '0;
            fmt_p1      <= 2'b00;
            chk_pend_p1 <= 1'b0;
            chk_fail_p2 <= 1'b0;
        end else begin
            chk_pend_p1 <= acc_p0;
            if (acc_p0) begin
                imm_p1 <= in_imm;
                fmt_p1 <= in_fmt;
            end
            if (clr)
                chk_fail_p2 <= 1'b0;
            else if (chk_pend_p1 && !err_p1 && (expand_imm(fmt_p1, inst_p1) != imm_p1))
                chk_fail_p2 <= 1'b1;
        end
    end

    assign chk_fail = chk_fail_p2;
`else
    assign chk_fail = 1'b0;
`endif

endmodule

// File: tb/tb_imm_packer.sv
// Self-checking bench for imm_packer: directed format vectors, backpressure, counters and a
// randomized run against a behavioural model built from the ISA byte-offset encodings.
module tb_imm_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_fmt = 2'b00;
    logic [31:0] in_base = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        out_err;
    logic        clr = 1'b0;
    logic [15:0] enc_cnt;
    logic [7:0]  err_cnt;
    logic        chk_fail;

    int n_cmp = 0;
    int n_fail = 0;

    imm_packer #(.CNT_W(16), .ERR_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
        .in_base(in_base), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
        .clr(clr), .enc_cnt(enc_cnt), .err_cnt(err_cnt), .chk_fail(chk_fail)
    );

    always #5 clk = ~clk;

    // Reference: B/J fields are described from the byte offset (imm << 1), as in the ISA manual.
    function automatic logic [31:0] ref_pack(input logic [1:0] fmt, input logic [31:0] base,
                                             input logic [31:0] imm);
        logic [31:0] off;
        logic [31:0] field;
        logic [31:0] mask;
        off = imm << 1;
        case (fmt)
            2'd0: begin
                mask  = 32'hFFF0_0000;
                field = (imm & 32'hFFF) << 20;
            end
            2'd1: begin
                mask  = 32'hFE00_0F80;
                field = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            end
            2'd2: begin
                mask  = 32'hFE00_0F80;
                field = (32'(off[12]) << 31) | (32'(off[10:5]) << 25) |
                        (32'(off[4:1]) << 8) | (32'(off[11]) << 7);
            end
            default: begin
                mask  = 32'hFFFF_F000;
                field = (32'(off[20]) << 31) | (32'(off[10:1]) << 21) |
                        (32'(off[11]) << 20) | (32'(off[19:12]) << 12);
            end
        endcase
        return (base & ~mask) | field;
    endfunction

    function automatic logic ref_err(input logic [1:0] fmt, input logic [31:0] imm);
        int signed v;
        v = $signed(imm);
        if (fmt == 2'd3)
            return (v < -524288) || (v > 524287);
        return (v < -2048) || (v > 2047);
    endfunction

    function automatic logic [31:0] rand_imm(input logic [1:0] fmt, input bit in_range);
        int signed v;
        int signed lo;
        lo = (fmt == 2'd3) ? -524288 : -2048;
        if (!in_range)
            return $urandom;
        case ($urandom_range(0, 5))
            0: v = lo;
            1: v = -lo - 1;
            default: v = int'($urandom_range(0, 32'(-2 * lo - 1))) + lo;
        endcase
        return 32'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [1:0] fmt, input logic [31:0] base, input logic [31:0] imm);
        in_fmt  = fmt;
        in_base = base;
        in_imm  = imm;
    endtask

    task automatic test_reset();
        #2;
        n_cmp += 6;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        if (out_inst !== 32'h0) begin n_fail++; $display("FAIL rst_out_inst got %h want 0", out_inst); end
        if (out_err !== 1'b0) begin n_fail++; $display("FAIL rst_out_err got %b want 0", out_err); end
        if (enc_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_enc_cnt got %0d want 0", enc_cnt); end
        if (err_cnt !== 8'h0) begin n_fail++; $display("FAIL rst_err_cnt got %0d want 0", err_cnt); end
        if (chk_fail !== 1'b0) begin n_fail++; $display("FAIL rst_chk_fail got %b want 0", chk_fail); end
        tick();
        rst = 1'b0;
        tick();
        // Load one word, then reset mid-transfer without a clock edge.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_req(2'd0, 32'h0000_0013, 32'h0000_0123);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_valid got %b want 1", out_valid); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got %b want 0", out_valid); end
        if (out_inst !== 32'h0) begin n_fail++; $display("FAIL async_rst_inst got %h want 0", out_inst); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_formats();
        logic [1:0]  fm [0:2];
        logic [31:0] bs [0:2];
        logic [31:0] im [0:2];
        logic [31:0] ex [0:2];
        fm[0] = 2'd0; bs[0] = 32'h0000_0013; im[0] = 32'hFFFF_FFFF; ex[0] = 32'hFFF0_0013;
        fm[1] = 2'd1; bs[1] = 32'h0000_2023; im[1] = 32'h0000_0024; ex[1] = 32'h0200_2223;
        fm[2] = 2'd2; bs[2] = 32'h0000_0063; im[2] = 32'hFFFF_FFFE; ex[2] = 32'hFE00_0EE3;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(fm[i], bs[i], im[i]);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            n_cmp += 3;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fmt%0d_valid got %b want 1", i, out_valid); end
            if (out_inst !== ex[i]) begin n_fail++; $display("FAIL fmt%0d_inst got %h want %h", i, out_inst, ex[i]); end
            if (out_err !== 1'b0) begin n_fail++; $display("FAIL fmt%0d_err got %b want 0", i, out_err); end
            tick();
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp += 2;
        if (enc_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_enc got %0d want 0", enc_cnt); end
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_err got %0d want 0", err_cnt); end
        set_req(2'd3, 32'h0000_006F, 32'h0008_0000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp += 4;
        if (out_inst !== 32'h8000_006F) begin n_fail++; $display("FAIL j_inst got %h want 8000006f", out_inst); end
        if (out_err !== 1'b1) begin n_fail++; $display("FAIL j_err got %b want 1", out_err); end
        if (enc_cnt !== 16'd1) begin n_fail++; $display("FAIL j_enc_cnt got %0d want 1", enc_cnt); end
        if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL j_err_cnt got %0d want 1", err_cnt); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] held;
        logic [1:0]  f;
        logic [31:0] b;
        logic [31:0] m;
        out_ready = 1'b0;
        f = 2'($urandom_range(0, 3)); b = $urandom; m = rand_imm(f, 1'b1);
        set_req(f, b, m);
        held = ref_pack(f, b, m);
        in_valid = 1'b1;
        tick();
        f = 2'($urandom_range(0, 3)); b = $urandom; m = rand_imm(f, 1'b1);
        set_req(f, b, m);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp += 3;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc%0d got %b want 0", i, in_ready); end
            tick();
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc%0d got %b want 1", i, out_valid); end
            if (out_inst !== held) begin n_fail++; $display("FAIL bp_hold cyc%0d got %h want %h", i, out_inst, held); end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp += 2;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cyc%0d got %b want 1", i, in_ready); end
            held = ref_pack(in_fmt, in_base, in_imm);
            tick();
            if (out_inst !== held) begin n_fail++; $display("FAIL b2b_inst cyc%0d got %h want %h", i, out_inst, held); end
            f = 2'($urandom_range(0, 3)); b = $urandom; m = rand_imm(f, 1'b1);
            set_req(f, b, m);
        end
        in_valid = 1'b0;
        tick();
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid got %b want 0", out_valid); end
        if (out_inst !== held) begin n_fail++; $display("FAIL drain_keep got %h want %h", out_inst, held); end
    endtask

    task automatic test_counters();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_valid = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            set_req(2'($urandom_range(0, 3)), $urandom, 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF));
            tick();
            if (i == 254) begin
                n_cmp++;
                if (err_cnt !== 8'd254) begin n_fail++; $display("FAIL err_cnt_254 got %0d want 254", err_cnt); end
            end
        end
        in_valid = 1'b0;
        n_cmp += 2;
        if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_cnt_sat got %0d want 255", err_cnt); end
        if (enc_cnt !== 16'd300) begin n_fail++; $display("FAIL enc_cnt_300 got %0d want 300", enc_cnt); end
        set_req(2'd3, 32'h0000_006F, 32'h0008_0000);
        in_valid = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        n_cmp += 3;
        if (enc_cnt !== 16'd0) begin n_fail++; $display("FAIL clr_acc_enc got %0d want 0", enc_cnt); end
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_acc_err got %0d want 0", err_cnt); end
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_acc_valid got %b want 1", out_valid); end
        tick();
    endtask

    task automatic test_random(input int cycles, input bit in_range_only);
        bit          m_vld;
        logic [31:0] m_inst;
        logic        m_err;
        int          m_enc;
        int          m_errc;
        bit          acc;
        logic [1:0]  f;
        m_vld = 1'b0; m_inst = '0; m_err = 1'b0; m_enc = 0; m_errc = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            f = 2'($urandom_range(0, 3));
            set_req(f, $urandom, rand_imm(f, in_range_only || ($urandom_range(0, 2) != 0)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = in_range_only || ($urandom_range(0, 2) != 0);
            #1;
            n_cmp += 2;
            if (in_ready !== (!m_vld || out_ready)) begin
                n_fail++; $display("FAIL rnd_in_ready cyc%0d got %b want %b", c, in_ready, !m_vld || out_ready);
            end
            if (out_valid !== m_vld) begin n_fail++; $display("FAIL rnd_valid cyc%0d got %b want %b", c, out_valid, m_vld); end
            if (m_vld) begin
                n_cmp += 2;
                if (out_inst !== m_inst) begin n_fail++; $display("FAIL rnd_inst cyc%0d got %h want %h", c, out_inst, m_inst); end
                if (out_err !== m_err) begin n_fail++; $display("FAIL rnd_err cyc%0d got %b want %b", c, out_err, m_err); end
            end
            acc = in_valid && (!m_vld || out_ready);
            if (acc) begin
                m_inst = ref_pack(in_fmt, in_base, in_imm);
                m_err  = ref_err(in_fmt, in_imm);
                m_vld  = 1'b1;
                m_enc++;
                if (m_err && m_errc < 255) m_errc++;
            end else if (out_ready) begin
                m_vld = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        n_cmp += 3;
        if (enc_cnt !== 16'(m_enc)) begin n_fail++; $display("FAIL rnd_enc_cnt got %0d want %0d", enc_cnt, m_enc); end
        if (err_cnt !== 8'(m_errc)) begin n_fail++; $display("FAIL rnd_err_cnt got %0d want %0d", err_cnt, m_errc); end
        if (chk_fail !== 1'b0) begin n_fail++; $display("FAIL rnd_chk_fail got %b want 0", chk_fail); end
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_counters();
        test_random(500, 1'b0);
        test_random(200, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_packer.md
# imm_packer

Immediate packer for the single-cycle CPU's instruction path: the inverse of the immediate expander. It takes a base instruction word with opcode, register and funct fields already placed, plus an immediate in the expander's output convention, and scatters the immediate bits into the I/S/B/J field positions. It range-checks the immediate and returns the finished word through a registered valid/ready stage. Test-program generators and the debug instruction injector use it to build instruction words for instruction memory.

## Interface
Parameters:
- `CNT_W`, default 16: width of the encoded-instruction counter.
- `ERR_W`, default 8: width of the saturating error counter.

Ports:
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: request valid.
- `in_ready`, output, 1: request accepted on a cycle where `in_valid` and `in_ready` are both 1.
- `in_fmt`, input, 2: format code. 00 = I (addi/lw), 01 = S (sw), 10 = B (beq), 11 = J (jal).
- `in_base`, input, 32: base instruction word. Bits in the format's immediate field are ignored.
- `in_imm`, input, 32: immediate. I and S formats take the byte value. B and J formats take the halfword-unit value, i.e. the byte offset >> 1, matching the expander's output.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer ready.
- `out_inst`, output, 32: packed instruction word.
- `out_err`, output, 1: `in_imm` was not representable in the format.
- `clr`, input, 1: synchronous clear of both counters.
- `enc_cnt`, output, `CNT_W`: number of accepted requests. Wraps.
- `err_cnt`, output, `ERR_W`: number of accepted requests with an error. Saturates.
- `chk_fail`, output, 1: round-trip mismatch flag (see Configuration).

## Operation
Packing. Field bits are overwritten; all other bits pass through from `in_base`.
- I: inst[31:20] = imm[11:0].
- S: inst[31:25] = imm[11:5]; inst[11:7] = imm[4:0].
- B: inst[31] = imm[11]; inst[30:25] = imm[9:4]; inst[11:8] = imm[3:0]; inst[7] = imm[10].
- J: inst[31] = imm[19]; inst[30:21] = imm[9:0]; inst[20] = imm[10]; inst[19:12] = imm[18:11].

Range check:
- I, S, B: `out_err` = 1 unless imm[31:12] equals 20 copies of imm[11].
- J: `out_err` = 1 unless imm[31:20] equals 12 copies of imm[19].
- An erroring word is still emitted, with the immediate truncated to the field width.

Counters:
- On accept, `enc_cnt` increments and wraps.
- On accept with an error, `err_cnt` increments and saturates at 2^ERR_W − 1.
- `clr` forces both counters to 0 and takes priority over a same-cycle accept; that accept is not counted.

## Timing
- Reset values: `out_valid` = 0, `out_inst` = 0, `out_err` = 0, `enc_cnt` = 0, `err_cnt` = 0, `chk_fail` = 0.
- A reset asserted mid-transfer discards the held result.
- `in_ready` = !`out_valid` || `out_ready`. It is combinational and has no dependency on `in_valid`.
- Latency is 1 cycle: a request accepted at edge N is presented at `out_*` after edge N.
- When accept and drain happen in the same cycle, the register loads the new result, so full throughput is 1 word per cycle.
- While `out_valid` = 1 and `out_ready` = 0, `out_inst` and `out_err` hold stable.
- If drain happens with no accept, `out_valid` falls to 0 at the edge. `out_inst` keeps its last value.

## Configuration
- `IMM_PACKER_ROUNDTRIP_EN` defined:
  - An internal expander re-derives the immediate from the registered `out_inst` using the mapping above, with sign extension from bit 11 (I/S/B) or bit 19 (J).
  - `chk_fail` is a registered flag, updated on each accept, set to 1 when the re-derived value differs from the accepted `in_imm` and `out_err` = 0.
  - `chk_fail` is sticky until `rst` or `clr`.
- Macro not defined: no checker logic is built and `chk_fail` is tied to 0.

## Test plan
- I format: base 0x00000013, imm 0xFFFFFFFF. Required: `out_inst` = 0xFFF00013 and `out_err` = 0, one cycle after accept.
- S format: base 0x00002023, imm 0x00000024. Required: `out_inst` = 0x02002223.
- B format: base 0x00000063, imm 0xFFFFFFFE (−4 bytes). Required: `out_inst` = 0xFE000EE3, `out_err` = 0.
- J format: base 0x0000006F, imm 0x00080000. Required: `out_err` = 1, `out_inst` = 0x8000006F, `err_cnt` 0 → 1, `enc_cnt` 0 → 1.
- Backpressure: hold `out_ready` = 0 for 3 cycles with `in_valid` = 1. Required: `in_ready` = 0 throughout and `out_inst` stable. Then assert `out_ready` = 1 for back-to-back transfers. Required: one word per cycle and no loss.
- Counters: 300 erroring accepts. Required: `err_cnt` = 255 and `enc_cnt` = 300. Then `clr` in the same cycle as an accept. Required: both counters read 0 the next cycle.
- With `IMM_PACKER_ROUNDTRIP_EN` defined, randomized in-range requests. Required: `chk_fail` stays 0.
